sprite_line_fetcher: RTL and testbench
======================================

# sprite_line_fetcher

Feeds the nine pixel shift registers (8 sprite, 1 background) that sit in front of the palette stage of the video pipeline. Each 16-pixel row is one 32-bit word at 2 bpp, with pixel 0 in bits [1:0].
- **Horizontal blank:** reads the sprite attribute table and pattern memory for the coming line, then loads all sprite rows and the first background row in one pulse.
- **Active line:** streams one background tile row per 16 pixels and generates the per-register shift enables.

## Interface
- `NUM_COLS`, default 40: background tiles per line. 16 px each, so 640 px.
- `clk`  in  1  system clock, 2x pixel rate.
- `reset`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse at the start of horizontal blank.
- `next_line`  in  10  line about to be displayed; sampled on `line_start`.
- `active`  in  1  high during visible pixels.
- `hcount`  in  10  visible column 0..639; valid while `active`.
- `pixel_tick`  in  1  one cycle per pixel; never high in two consecutive cycles.
- `attr_rd`  out  1  attribute read strobe.
- `attr_addr`  out  3  sprite index.
- `attr_data`  in  32  attribute word, 1-cycle latency.
  - Fields: y [9:0], x [19:10], tile [27:20], hflip [30], visible [31].
- `map_rd`  out  1  tile-map read strobe.
- `map_addr`  out  11  tile-map index.
- `map_data`  in  8  tile index, 1-cycle latency.
- `pat_rd`  out  1  pattern read strobe.
- `pat_addr`  out  12  pattern row address: {tile, row[3:0]}.
- `pat_data`  in  32  pattern row, 1-cycle latency.
- `load_data`  out  9x32  [7:0] sprite rows, [8] background row.
- `load_sprite`  out  1  loads sprite registers 0..7.
- `load_background`  out  1  loads background register.
- `enable`  out  9  per-register shift enables.

## Operation
- **Reset:** all outputs are 0. FSM is IDLE; all staging registers, hit flags and x latches are 0.
- **`line_start`:** latches `next_line` (L), clears the column counter, and enters SPR_ATTR with i=0. This happens from any state; a fetch in progress is abandoned.
- **Sprite fetch (per sprite):**
  - SPR_ATTR: issue `attr_rd` for sprite i.
  - SPR_CHK: compute row = L - y, mod 1024. hit = visible && row < 16.
    - Latch x_i and hit_i.
    - If hit: issue `pat_rd` at {tile, row[3:0]}.
    - If not hit: staging_i = 0 (transparent).
  - SPR_PAT: capture `pat_data` into staging_i. Then i+1, or go to BG_MAP after i=7.
- **Background fetch:**
  - BG_MAP: `map_rd` at (L>>4)*NUM_COLS + col.
  - BG_PAT: `pat_rd` at {map_data, L[3:0]}.
  - BG_CAP: capture into bg staging.
- **LOAD (after first fetch of the line):** `load_sprite` and `load_background` are high for one cycle, with `load_data` = staging. Then set col=1 and go to STREAM.
- **STREAM:**
  - On the tick where `active` && hcount[3:0]==0 && col<NUM_COLS: run BG_MAP/BG_PAT/BG_CAP for col, then return to WAIT_EDGE.
  - On the cycle after the tick where hcount[3:0]==15: pulse `load_background` with the staged row, then col+1.
  - After col reaches NUM_COLS, no further fetch; go to IDLE when `active` falls.
- **Enables:**
  - enable[8] = `pixel_tick` && `active`.
  - enable[i] = `pixel_tick` && `active` && hit_i && (hcount - x_i) mod 1024 < 16. Exactly 16 shifts per visible sprite; a sprite at x>624 is clipped.
- Sprite hit flags and x latches update only at LOAD. The enables for the current line use the previous LOAD's values.

## Timing
- A read strobe in cycle t gives data captured in cycle t+1.
- Sprite + first background fetch completes in ≤38 cycles from `line_start` to the LOAD pulse. Horizontal blank must be ≥40 clk.
- `load_*` are asserted only in non-tick cycles, so they never coincide with their own `enable` bits.
- Per-column stream fetch takes 4 cycles and finishes well inside the 32-cycle span.
- `line_start` during STREAM aborts the stream; `load_background` is not pulsed for that partial column.
- Reset mid-line: outputs are 0 immediately (asynchronous); the fetcher resumes at the next `line_start`.

## Configuration
- **`SPRITE_FLIP_EN` defined:** when hflip=1, the sprite row is stored with its 16 two-bit pixels reversed (pixel 15 goes to bits [1:0]).
- **`SPRITE_FLIP_EN` undefined:** bit 30 is ignored and rows load unmodified. The background is never flipped in either case.

## Test plan
- Reset asserted mid-fetch → all outputs 0 within the same cycle; no `load_*` pulse until after the next `line_start`.
- Sprite 3 with y=100, x=200, tile=5, visible; `line_start` with L=103 → `pat_addr`=0x053; load_data[3]=`pat_data`; enable[3] high on ticks for hcount 200..215 only.
- Sprite with y=1020 and L=4 (wrap case, row=8) → hit, `pat_addr` row 8. Sprite with y=50 and L=66 (row=16) → no hit, load_data=0, enable never high.
- Background stream with map returning tile=col → `load_background` once per 16 px, in the cycle after the tick at hcount 15, 31, ...; 40 loads per line counting the LOAD pulse; `pat_addr`={col, L[3:0]}.
- `line_start` re-pulsed during sprite fetch i=4 → fetch restarts at i=0 with the new L; only one LOAD pulse occurs.
- With `SPRITE_FLIP_EN`: hflip=1 and `pat_data`=0x0000_0001 → load_data[i]=0x4000_0000. Without the macro → 0x0000_0001.

Source files
------------

// File: rtl/sprite_line_fetcher.sv
// Fetches sprite rows and background tile rows for the pixel shift registers ahead of the palette stage.
// Build option: define SPRITE_FLIP_EN to honour the attribute hflip bit when staging sprite rows.
module sprite_line_fetcher #(
  parameter int unsigned NUM_COLS = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic [9:0]       next_line,
  input  logic             active,
  input  logic [9:0]       hcount,
  input  logic             pixel_tick,
  output logic             attr_rd,
  output logic [2:0]       attr_addr,
  input  logic [31:0]      attr_data,
  output logic             map_rd,
  output logic [10:0]      map_addr,
  input  logic [7:0]       map_data,
  output logic             pat_rd,
  output logic [11:0]      pat_addr,
  input  logic [31:0]      pat_data,
  output logic [8:0][31:0] load_data,
  output logic             load_sprite,
  output logic             load_background,
  output logic [8:0]       enable
);

`ifdef SPRITE_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif
  localparam logic [10:0] NCOLS = 11'(NUM_COLS);

  typedef enum logic [3:0] {
    IDLE, SPR_ATTR, SPR_CHK, SPR_PAT, BG_MAP, BG_PAT, BG_CAP, LOAD, WAIT_EDGE
  } state_t;

  state_t             state;
  logic [9:0]         line;
  logic [10:0]        map_base;
  logic [10:0]        col;
  logic [2:0]         spr_idx;
  logic               first_fetch;
  logic               streaming;
  logic [8:0][31:0]   staging;
  logic [7:0]         hit_stage;
  logic [7:0][9:0]    x_stage;
  logic [7:0]         hit_cur;
  logic [7:0][9:0]    x_cur;
  logic [3:0]         pat_idx;
  logic               pat_flip;
  logic               cap_en;
  logic [3:0]         cap_idx;
  logic               cap_flip;

  logic [9:0]         spr_row;
  logic               spr_hit;
  logic [31:0]        cap_word;
  logic               tick_act;
  logic               unused_attr;

  function automatic logic [31:0] flip_row(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int unsigned k = 0; k < 16; k++) r[2*k +: 2] = w[2*(15-k) +: 2];
    return r;
  endfunction

  assign spr_row     = line - attr_data[9:0];
  assign spr_hit     = attr_data[31] && (spr_row[9:4] == '0);
  assign cap_word    = cap_flip ? flip_row(pat_data) : pat_data;
  assign load_data   = staging;
  assign unused_attr = ^attr_data[29:28];

  always_comb begin
    tick_act = reset && pixel_tick && active;
    enable   = '0;
    for (int unsigned i = 0; i < 8; i++)
      enable[i] = tick_act && hit_cur[i] && (10'(hcount - x_cur[i]) < 10'd16);
    enable[8] = tick_act;
  end

  // Pattern data returns one cycle after pat_rd; the cap_* pipeline stage writes it to
  // its staging slot independently of where the FSM has moved on to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      line            <= '0;
      map_base        <= '0;
      col             <= '0;
      spr_idx         <= '0;
      first_fetch     <= 1'b0;
      streaming       <= 1'b0;
      staging         <= '0;
      hit_stage       <= '0;
      x_stage         <= '0;
      hit_cur         <= '0;
      x_cur           <= '0;
      pat_idx         <= '0;
      pat_flip        <= 1'b0;
      cap_en          <= 1'b0;
      cap_idx         <= '0;
      cap_flip        <= 1'b0;
      attr_rd         <= 1'b0;
      attr_addr       <= '0;
      map_rd          <= 1'b0;
      map_addr        <= '0;
      pat_rd          <= 1'b0;
      pat_addr        <= '0;
      load_sprite     <= 1'b0;
      load_background <= 1'b0;
    end else begin
      attr_rd         <= 1'b0;
      map_rd          <= 1'b0;
      pat_rd          <= 1'b0;
      load_sprite     <= 1'b0;
      load_background <= 1'b0;
      cap_en          <= pat_rd;
      cap_idx         <= pat_idx;
      cap_flip        <= pat_flip;
      if (cap_en) staging[cap_idx] <= cap_word;

      if (line_start) begin
        line        <= next_line;
        map_base    <= 11'(32'(next_line[9:4]) * NUM_COLS);
        col         <= '0;
        spr_idx     <= '0;
        first_fetch <= 1'b1;
        streaming   <= 1'b0;
        cap_en      <= 1'b0;
        attr_rd     <= 1'b1;
        attr_addr   <= '0;
        state       <= SPR_ATTR;
      end else begin
        if (streaming && pixel_tick && active && hcount[3:0] == 4'hF && col < NCOLS) begin
          load_background <= 1'b1;
          col             <= col + 11'd1;
        end

        case (state)
          IDLE: ;
          SPR_ATTR: state <= SPR_CHK;
          SPR_CHK: begin
            x_stage[spr_idx]   <= attr_data[19:10];
            hit_stage[spr_idx] <= spr_hit;
            if (spr_hit) begin
              pat_rd   <= 1'b1;
              pat_addr <= {attr_data[27:20], spr_row[3:0]};
              pat_idx  <= {1'b0, spr_idx};
              pat_flip <= FLIP_EN & attr_data[30];
            end else begin
              staging[spr_idx] <= '0;
            end
            state <= SPR_PAT;
          end
          SPR_PAT: begin
            if (spr_idx == 3'd7) begin
              map_rd   <= 1'b1;
              map_addr <= map_base + col;
              state    <= BG_MAP;
            end else begin
              spr_idx   <= spr_idx + 3'd1;
              attr_rd   <= 1'b1;
              attr_addr <= spr_idx + 3'd1;
              state     <= SPR_ATTR;
            end
          end
          BG_MAP: state <= BG_PAT;
          BG_PAT: begin
            pat_rd   <= 1'b1;
            pat_addr <= {map_data, line[3:0]};
            pat_idx  <= 4'd8;
            pat_flip <= 1'b0;
            state    <= BG_CAP;
          end
          BG_CAP: state <= first_fetch ? LOAD : WAIT_EDGE;
          LOAD: begin
            load_sprite     <= 1'b1;
            load_background <= 1'b1;
            hit_cur         <= hit_stage;
            x_cur           <= x_stage;
            col             <= 11'd1;
            first_fetch     <= 1'b0;
            streaming       <= 1'b1;
            state           <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (pixel_tick && active && hcount[3:0] == 4'h0 && col < NCOLS) begin
              map_rd   <= 1'b1;
              map_addr <= map_base + col;
              state    <= BG_MAP;
            end else if (col >= NCOLS && !active) begin
              streaming <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher: memory models, expected-output queues, enable model.
module tb_sprite_line_fetcher;
  localparam int unsigned NUM_COLS = 40;

  logic             clk = 1'b0;
  logic             reset;
  logic             line_start;
  logic [9:0]       next_line;
  logic             active;
  logic [9:0]       hcount;
  logic             pixel_tick;
  logic             attr_rd;
  logic [2:0]       attr_addr;
  logic [31:0]      attr_data = '0;
  logic             map_rd;
  logic [10:0]      map_addr;
  logic [7:0]       map_data = '0;
  logic             pat_rd;
  logic [11:0]      pat_addr;
  logic [31:0]      pat_data = '0;
  logic [8:0][31:0] load_data;
  logic             load_sprite;
  logic             load_background;
  logic [8:0]       enable;

  always #5 clk = ~clk;

  sprite_line_fetcher #(.NUM_COLS(NUM_COLS)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .next_line(next_line),
    .active(active), .hcount(hcount), .pixel_tick(pixel_tick),
    .attr_rd(attr_rd), .attr_addr(attr_addr), .attr_data(attr_data),
    .map_rd(map_rd), .map_addr(map_addr), .map_data(map_data),
    .pat_rd(pat_rd), .pat_addr(pat_addr), .pat_data(pat_data),
    .load_data(load_data), .load_sprite(load_sprite),
    .load_background(load_background), .enable(enable)
  );

  typedef logic [7:0][31:0] rows_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] attr_mem [8];
  logic        pat_force_en = 1'b0;
  logic [31:0] pat_force_val = '0;
  logic [11:0] exp_pat [$];
  logic [31:0] exp_bg [$];
  rows_t       exp_spr [$];
  logic [7:0]  pend_hit = '0;
  logic [9:0]  pend_x [8];
  logic [7:0]  mhit = '0;
  logic [9:0]  mx [8];
  logic [9:0]  cur_l = '0;
  int          bg_cnt = 0;
  int          spr_cnt = 0;
  int          en_cnt [8];
  int          ls_age = 0;
  logic        prev15 = 1'b0;

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] patfn(input logic [11:0] a);
    if (pat_force_en) return pat_force_val;
    return {a, 4'h5, ~a[7:0], a[11:4]};
  endfunction

  function automatic logic [31:0] flipfn(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[2*k +: 2] = w[2*(15-k) +: 2];
    return r;
  endfunction

  // Memory models: one-cycle read latency
  always @(posedge clk) begin
    if (attr_rd) attr_data <= attr_mem[attr_addr];
    if (map_rd)  map_data  <= 8'(map_addr % 11'd40);
    if (pat_rd)  pat_data  <= patfn(pat_addr);
  end

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    logic [11:0] ea;
    logic [31:0] eb;
    rows_t       er;
    logic [8:0]  ee;
    logic        ta;
    if (!reset) mhit = '0;
    ta = reset && pixel_tick && active;
    ee = '0;
    ee[8] = ta;
    for (int i = 0; i < 8; i++) ee[i] = ta && mhit[i] && (10'(hcount - mx[i]) < 10'd16);
    chk("enable", enable, ee);
    for (int i = 0; i < 8; i++) if (enable[i]) en_cnt[i]++;

    if (pat_rd) begin
      if (exp_pat.size() == 0) chk("pat_rd_unexpected", pat_rd, 0);
      else begin
        ea = exp_pat.pop_front();
        chk("pat_addr", pat_addr, ea);
      end
    end
    if (map_rd) chk("map_row", map_addr / 11'd40, cur_l[9:4]);

    if (load_sprite || load_background) chk("load_not_tick", pixel_tick, 0);
    if (load_background) begin
      bg_cnt++;
      if (!load_sprite) chk("bg_load_timing", prev15, 1);
      if (exp_bg.size() == 0) chk("bg_load_unexpected", load_background, 0);
      else begin
        eb = exp_bg.pop_front();
        chk("bg_row", load_data[8], eb);
      end
    end
    if (load_sprite) begin
      spr_cnt++;
      chk("load_latency", 32'(ls_age <= 38), 1);
      if (exp_spr.size() == 0) chk("spr_load_unexpected", load_sprite, 0);
      else begin
        er = exp_spr.pop_front();
        chk("spr_rows", load_data[7:0], er);
      end
      mhit = pend_hit;
      for (int i = 0; i < 8; i++) mx[i] = pend_x[i];
    end

    prev15 = pixel_tick && active && hcount[3:0] == 4'hF;
    if (line_start) ls_age = 0;
    else ls_age++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ls(input logic [9:0] l);
    line_start = 1'b1;
    next_line  = l;
    step();
    line_start = 1'b0;
  endtask

  task automatic run_line(input logic [9:0] l);
    pulse_ls(l);
    repeat (47) step();
    for (int h = 0; h < 640; h++) begin
      active = 1'b1;
      hcount = 10'(h);
      pixel_tick = 1'b1;
      step();
      pixel_tick = 1'b0;
      step();
    end
    active = 1'b0;
    hcount = '0;
    repeat (8) step();
  endtask

  task automatic begin_line();
    bg_cnt = 0;
    spr_cnt = 0;
    for (int i = 0; i < 8; i++) en_cnt[i] = 0;
  endtask

  task automatic expect_line(input logic [9:0] l);
    rows_t       rows;
    logic [31:0] a;
    logic [9:0]  row;
    logic [11:0] pa;
    logic [7:0]  c8;
    logic [31:0] w;
    cur_l = l;
    rows = '0;
    for (int i = 0; i < 8; i++) begin
      a = attr_mem[i];
      row = l - a[9:0];
      pend_hit[i] = a[31] && (row < 10'd16);
      pend_x[i] = a[19:10];
      if (pend_hit[i]) begin
        pa = {a[27:20], row[3:0]};
        exp_pat.push_back(pa);
        w = patfn(pa);
`ifdef SPRITE_FLIP_EN
        if (a[30]) w = flipfn(w);
`endif
        rows[i] = w;
      end
    end
    exp_spr.push_back(rows);
    for (int c = 0; c < NUM_COLS; c++) begin
      c8 = 8'(c);
      pa = {c8, l[3:0]};
      exp_pat.push_back(pa);
      exp_bg.push_back(patfn(pa));
    end
  endtask

  task automatic end_line_checks();
    int ec;
    chk("pat_pending", exp_pat.size(), 0);
    chk("bg_pending", exp_bg.size(), 0);
    chk("spr_pending", exp_spr.size(), 0);
    chk("bg_load_count", bg_cnt, NUM_COLS);
    chk("spr_load_count", spr_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      ec = !pend_hit[i] ? 0 : (pend_x[i] <= 10'd624) ? 16 : 640 - int'(pend_x[i]);
      chk($sformatf("en_count%0d", i), en_cnt[i], ec);
    end
  endtask

  function automatic logic [31:0] mk_attr(input logic vis, input logic hf, input logic [7:0] tile,
                                          input logic [9:0] x, input logic [9:0] y);
    return {vis, hf, 2'b00, tile, x, y};
  endfunction

  initial begin
    reset = 1'b0;
    line_start = 1'b0;
    next_line = '0;
    active = 1'b0;
    hcount = '0;
    pixel_tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pend_x[i] = '0;
      mx[i] = '0;
      en_cnt[i] = 0;
    end
    attr_mem[0] = mk_attr(1'b1, 1'b1, 8'h11, 10'd40,  10'd1020);
    attr_mem[1] = mk_attr(1'b1, 1'b0, 8'h22, 10'd300, 10'd50);
    attr_mem[2] = mk_attr(1'b0, 1'b0, 8'h33, 10'd10,  10'd100);
    attr_mem[3] = mk_attr(1'b1, 1'b0, 8'h05, 10'd200, 10'd100);
    attr_mem[4] = mk_attr(1'b1, 1'b0, 8'h44, 10'd630, 10'd96);
    attr_mem[5] = mk_attr(1'b1, 1'b1, 8'h55, 10'd0,   10'd103);
    attr_mem[6] = mk_attr(1'b1, 1'b0, 8'h66, 10'd500, 10'd0);
    attr_mem[7] = mk_attr(1'b1, 1'b0, 8'h77, 10'd100, 10'd60);

    repeat (3) step();
    chk("rst_strobes", {attr_rd, map_rd, pat_rd, load_sprite, load_background}, 0);
    chk("rst_addrs", {attr_addr, map_addr, pat_addr}, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_enable", enable, 0);
    reset = 1'b1;
    repeat (2) step();

    // Line 103: sprite 3 at pat 0x053, sprite 4 clipped, sprite 5 row 0
    begin_line(); expect_line(10'd103); run_line(10'd103); end_line_checks();
    // Line 4: sprite 0 wraps (y=1020, row 8), sprite 6 row 4
    begin_line(); expect_line(10'd4); run_line(10'd4); end_line_checks();
    // Line 66: sprite 1 is at row 16 (miss), sprite 7 hits
    begin_line(); expect_line(10'd66); run_line(10'd66); end_line_checks();
    // Restart during sprite 4 check; only the restarted fetch may load
    begin_line(); expect_line(10'd103);
    pulse_ls(10'd300);
    repeat (13) step();
    run_line(10'd103); end_line_checks();
    // Forced pattern word 1: flipped sprite rows become 0x4000_0000 when the flip build is used
    pat_force_en = 1'b1; pat_force_val = 32'h0000_0001;
    begin_line(); expect_line(10'd103); run_line(10'd103); end_line_checks();
    pat_force_en = 1'b0;

    // Asynchronous reset in the middle of the sprite fetch
    begin_line();
    pulse_ls(10'd103);
    repeat (9) step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_strobes", {attr_rd, map_rd, pat_rd, load_sprite, load_background}, 0);
    chk("midrst_addrs", {attr_addr, map_addr, pat_addr}, 0);
    chk("midrst_load_data", load_data, 0);
    chk("midrst_enable", enable, 0);
    exp_pat.delete(); exp_bg.delete(); exp_spr.delete();
    repeat (3) step();
    reset = 1'b1;
    repeat (60) step();
    chk("loads_after_reset", spr_cnt + bg_cnt, 0);
    begin_line(); expect_line(10'd4); run_line(10'd4); end_line_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
